tree_node_mux: RTL
==================

# tree_node_mux

Parametrised N-to-1 merge node for the generated module hierarchy, next generation of the fixed five-child container nodes. Each of NUM_CHILDREN child streams is buffered in its own small FIFO. A round-robin arbiter, optionally packet-locked, merges the buffered beats into one registered upstream stream tagged with the source child index. Nodes cascade to form arbitrary-depth trees: one node's upstream port drives a parent node's child port.

## Interface
Parameters:
- NUM_CHILDREN, 5, number of child channels (1..32)
- DATA_W, 32, payload width
- FIFO_DEPTH, 4, per-child FIFO entries; power of two, ≥2
- PKT_MODE, 0, 0 = beat-level arbitration; 1 = grant held until a beat with last=1

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- child_valid  in  NUM_CHILDREN  per-child beat valid
- child_ready  out  NUM_CHILDREN  per-child accept
- child_data  in  NUM_CHILDREN×DATA_W  per-child payload
- child_last  in  NUM_CHILDREN  per-child end-of-packet
- up_valid  out  1  upstream beat valid
- up_ready  in  1  upstream accept
- up_data  out  DATA_W  upstream payload
- up_last  out  1  upstream end-of-packet
- up_id  out  ID_W  source child index, ID_W = max(1, clog2(NUM_CHILDREN))
- fifo_level  out  NUM_CHILDREN×(clog2(FIFO_DEPTH)+1)  per-child occupancy

## Operation
- Handshake: a transfer happens when valid && ready on the same edge. Valid never drops and payload never changes while valid=1 && ready=0.
- child_ready[i] = !full[i], decoded from the registered count and independent of child_valid. Push and pop on the same cycle leave the count unchanged.
- Output stage: a single register (up_valid/data/last/id). It loads when empty or when consumed this cycle, giving 1 beat/cycle sustained throughput.
- Arbiter: evaluates only when the output stage loads. Candidates are the non-empty FIFOs. The search starts at (last_grant+1) mod NUM_CHILDREN. The winner's head is popped into the output stage and last_grant is updated.
- PKT_MODE=1: after a beat with last=0 is popped from child k, lock=1 and only child k is eligible. If FIFO k is empty, the output stage idles; other children wait. A popped beat with last=1 clears lock and round-robin resumes from k+1.
- PKT_MODE=0: child_last is passed through unchanged and the lock is never set.
- No data loss or duplication. Per-child ordering is preserved. Cross-child interleaving follows arbitration.

## Timing
- Reset values: up_valid=0, up_data=0, up_last=0, up_id=0, fifo_level=0, child_ready all 1 (from the first edge after rst deasserts), last_grant=NUM_CHILDREN-1 so child 0 wins first, lock=0.
- Latency: child beat accepted at edge T appears with up_valid=1 after edge T+1, provided the output stage is free and the child wins. Minimum latency 1 cycle. No combinational path from child_* to up_*.
- No combinational path from up_ready to child_ready.
- FIFO full: child_ready[i]=0 from the edge the count reaches FIFO_DEPTH. A pop that same cycle re-asserts it after the next edge.
- All FIFOs empty with up_ready=1: up_valid drops after the current beat.
- FIFO pointers wrap modulo FIFO_DEPTH, and the count saturates logically at FIFO_DEPTH because push is blocked.
- rst mid-operation: all FIFOs flushed, output beat discarded, lock cleared, pointer reset. This applies regardless of in-flight packets.
- NUM_CHILDREN=1: the arbiter degenerates and up_id is constant 0.

## Structure
- Package tree_node_pkg holds:
  - ID_W and level-width functions (clog2-based)
  - beat_t struct typedef {data, last}, parametrised via a DATA_W localparam in the instantiating module
  - the round-robin next-index function
- Sub-module tree_node_fifo: synchronous FIFO with registered count, full/empty, async active-high reset. It is instantiated NUM_CHILDREN times in a generate loop.
- Arbiter and output register live in tree_node_mux.

## Test plan
- Reset: assert rst for 3 cycles, release → up_valid=0, child_ready=all 1, fifo_level=0. Single beat 0xA5 on child 2 → up_valid after 1 cycle with up_data=0xA5, up_id=2.
- Fairness, PKT_MODE=0, N=5, all children continuously valid, up_ready=1 → up_id sequence 0,1,2,3,4,0,… with no gaps for 20 beats.
- Backpressure: up_ready=0, child 1 pushes 6 beats, FIFO_DEPTH=4 → child_ready[1]=0 after 4 accepts plus the output beat, level=4. Release up_ready → all 5 beats delivered in order.
- Packet lock, PKT_MODE=1: child 0 sends 3-beat packet with a 2-cycle mid-packet gap, child 3 continuously valid → child 0's 3 beats contiguous in up_id order, then child 3 granted.
- Mid-packet reset: assert rst while up_valid=1 and FIFOs are half full → next cycle up_valid=0, fifo_level=0, lock cleared. Subsequent traffic arbitrates starting at child 0.
- Random stress: random valid/ready at 50% on all children, 10k beats → scoreboard shows per-child order preserved, no loss/duplication, payload stable under stall.

Source files
------------

// File: rtl/tree_node_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tree_node_pkg
// Description : Shared widths, arbiter states and round-robin helper for the
//               tree_node_mux merge node.
// Revision    : 1.0
// ============================================================================
package tree_node_pkg;

   typedef enum logic [0:0] {
      ARB_FREE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int rr_next(input int cur, input int n);
      return (cur + 1 >= n) ? 0 : cur + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tree_node_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tree_node_fifo
// Description : Synchronous FIFO with registered occupancy count and
//               full/empty flags decoded from that count.
// Revision    : 1.0
// ============================================================================
module tree_node_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             w_push;
   logic             w_pop;

   assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign w_push  = push_i && !full_o;
   assign w_pop   = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (w_push && !w_pop) begin
            count_q <= count_q + 1'b1;
         end else if (w_pop && !w_push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/tree_node_mux.sv
`default_nettype none
// ============================================================================
// Module      : tree_node_mux
// Description : N-to-1 merge node: per-child FIFOs, round-robin (optionally
//               packet-locked) arbiter and a registered upstream stage.
// Revision    : 1.0
// ============================================================================
module tree_node_mux
   import tree_node_pkg::*;
#(
   parameter int NUM_CHILDREN = 5,
   parameter int DATA_W       = 32,
   parameter int FIFO_DEPTH   = 4,
   parameter int PKT_MODE     = 0
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic [NUM_CHILDREN-1:0]                         child_valid,
   output logic [NUM_CHILDREN-1:0]                         child_ready,
   input  logic [NUM_CHILDREN*DATA_W-1:0]                  child_data,
   input  logic [NUM_CHILDREN-1:0]                         child_last,
   output logic                                            up_valid,
   input  logic                                            up_ready,
   output logic [DATA_W-1:0]                               up_data,
   output logic                                            up_last,
   output logic [id_width(NUM_CHILDREN)-1:0]               up_id,
   output logic [NUM_CHILDREN*level_width(FIFO_DEPTH)-1:0] fifo_level
);
   localparam int ID_W  = id_width(NUM_CHILDREN);
   localparam int LVL_W = level_width(FIFO_DEPTH);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } beat_t;

   beat_t                   w_head [NUM_CHILDREN];
   logic [NUM_CHILDREN-1:0] w_full;
   logic [NUM_CHILDREN-1:0] w_empty;
   logic [NUM_CHILDREN-1:0] w_pop;

   generate
      for (genvar g = 0; g < NUM_CHILDREN; g++) begin : g_child
         beat_t w_in;
         assign w_in = '{data: child_data[g*DATA_W +: DATA_W], last: child_last[g]};

         tree_node_fifo #(
            .WIDTH ($bits(beat_t)),
            .DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (child_valid[g]),
            .data_i  (w_in),
            .pop_i   (w_pop[g]),
            .data_o  (w_head[g]),
            .full_o  (w_full[g]),
            .empty_o (w_empty[g]),
            .count_o (fifo_level[g*LVL_W +: LVL_W])
         );

         assign child_ready[g] = !w_full[g];
      end
   endgenerate

   arb_state_e        state_q, state_d;
   logic [ID_W-1:0]   last_grant_q, last_grant_d;
   logic              up_valid_q;
   logic [DATA_W-1:0] up_data_q;
   logic              up_last_q;
   logic [ID_W-1:0]   up_id_q;
   logic              w_load;
   logic              w_found;
   logic [ID_W-1:0]   w_win;
   logic [ID_W-1:0]   w_idx;

   assign w_load   = !up_valid_q || up_ready;
   assign up_valid = up_valid_q;
   assign up_data  = up_data_q;
   assign up_last  = up_last_q;
   assign up_id    = up_id_q;

   // While locked only the last granted child is eligible, so no separate
   // lock owner register is needed.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = ID_W'(rr_next(int'(last_grant_q), NUM_CHILDREN));
      for (int n = 0; n < NUM_CHILDREN; n++) begin
         if (!w_found && !w_empty[w_idx] &&
             (state_q == ARB_FREE || w_idx == last_grant_q)) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
         w_idx = ID_W'(rr_next(int'(w_idx), NUM_CHILDREN));
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      w_pop        = '0;
      if (w_load && w_found) begin
         w_pop[w_win] = 1'b1;
         last_grant_d = w_win;
         if (PKT_MODE != 0 && !w_head[w_win].last) begin
            state_d = ARB_LOCKED;
         end else begin
            state_d = ARB_FREE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ARB_FREE;
         last_grant_q <= ID_W'(NUM_CHILDREN - 1);
         up_valid_q   <= 1'b0;
         up_data_q    <= '0;
         up_last_q    <= 1'b0;
         up_id_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         if (w_load) begin
            up_valid_q <= w_found;
            if (w_found) begin
               up_data_q <= w_head[w_win].data;
               up_last_q <= w_head[w_win].last;
               up_id_q   <= w_win;
            end
         end
      end
   end

endmodule
`default_nettype wire
